// File: rtl/seg_pkg.sv
// Shared constants, slot-state type and width helper for the seven-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h18;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } slot_state_t;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int cnt_width(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD nibbles and blank_in give all segments off.
module bcd_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank_in,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank_in) begin
      case (nibble)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin multiplexed seven-segment scanner with dead-time guard and frame-boundary double buffering.
// Outputs are registered one cycle behind the slot counter and digit index.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_blank,
  input  logic                    blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_tick
);

  localparam int CW = cnt_width(REFRESH_DIV);
  localparam int IW = cnt_width(NUM_DIGITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic [4*NUM_DIGITS-1:0] r_pend_val;
  logic                    r_pending;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_tick;

  logic                    w_slot_end;
  logic                    w_boundary;
  slot_state_t             w_state;
  logic [3:0]              w_nibble;
  logic [NUM_DIGITS-1:0]   w_an_drv;
  logic                    w_lz;
  logic                    w_zero_above;
  logic [6:0]              w_dec_seg;

  assign w_slot_end = (r_cnt == CNT_LAST);
  assign w_boundary = w_slot_end && (r_idx == IDX_LAST);
  assign w_state    = (r_cnt < CNT_DEAD) ? GUARD : DRIVE;

  // Walk from the most significant digit down so the zero run is known when the current digit is reached.
  always_comb begin
    w_nibble     = 4'd0;
    w_an_drv     = '1;
    w_lz         = 1'b0;
    w_zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above && (r_active[4*i +: 4] == 4'd0);
      if (r_idx == IW'(i)) begin
        w_nibble    = r_active[4*i +: 4];
        w_an_drv[i] = 1'b0;
        w_lz        = lz_blank && (i > 0) && w_zero_above;
      end
    end
  end

  bcd_seg_decode u_dec (
    .nibble   (w_nibble),
    .blank_in (w_lz),
    .seg      (w_dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_active     <= '0;
      r_pend_val   <= '0;
      r_pending    <= 1'b0;
      r_seg        <= SEG_BLANK;
      r_an         <= '1;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_slot_end ? '0 : r_cnt + 1'b1;
      r_frame_tick <= w_boundary;
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end

      if (blank || (w_state == GUARD)) begin
        r_an  <= '1;
        r_seg <= SEG_BLANK;
      end else begin
        r_an  <= w_an_drv;
        r_seg <= w_dec_seg;
      end

      // A load landing on the boundary bypasses the pending buffer entirely.
      if (w_boundary) begin
        if (load) begin
          r_active <= value;
        end else if (r_pending) begin
          r_active <= r_pend_val;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pend_val <= value;
        r_pending  <= 1'b1;
      end
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign pending    = r_pending;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench: a cycle-count based reference model pushes expected outputs, a monitor pops and compares.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int DC = 1;
  localparam int FR = ND * RD;

  typedef struct packed {
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          ft;
    logic          pend;
  } obs_t;

  logic          clk = 1'b0;
  logic          clk_en = 1'b0;
  logic          rst;
  logic          load;
  logic [4*ND-1:0] value;
  logic          lz_blank;
  logic          blank;
  logic [6:0]    seg;
  logic [ND-1:0] an;
  logic          pending;
  logic          frame_tick;

  int n_cmp = 0;
  int n_bad = 0;

  obs_t exp_q[$];

  int            m_cyc = 0;
  logic [4*ND-1:0] m_active = '0;
  logic [4*ND-1:0] m_pval = '0;
  logic          m_pend = 1'b0;

  logic [6:0] dec_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .DEAD_CYCLES (DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .lz_blank   (lz_blank),
    .blank      (blank),
    .seg        (seg),
    .an         (an),
    .pending    (pending),
    .frame_tick (frame_tick)
  );

  initial begin
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [4*ND-1:0] val, input int dig, input logic lz);
    int nib;
    nib = (val >> (4 * dig)) & 15;
    if (lz && dig > 0 && (val >> (4 * dig)) == 0) return 7'h7F;
    if (nib > 9) return 7'h7F;
    return dec_tab[nib];
  endfunction

  // Reference model: position in the scan follows purely from the edge count since reset.
  initial begin
    obs_t e;
    int pos, dig;
    logic bnd;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cyc    = 0;
        m_active = '0;
        m_pval   = '0;
        m_pend   = 1'b0;
      end else begin
        pos = m_cyc % RD;
        dig = (m_cyc / RD) % ND;
        bnd = ((m_cyc % FR) == FR - 1);
        if (blank || pos < DC) begin
          e.seg = 7'h7F;
          e.an  = '1;
        end else begin
          e.seg = ref_seg(m_active, dig, lz_blank);
          e.an  = ~(ND'(1) << dig);
        end
        e.ft = bnd;
        if (bnd) begin
          if (load) m_active = value;
          else if (m_pend) m_active = m_pval;
          m_pend = 1'b0;
        end else if (load) begin
          m_pval = value;
          m_pend = 1'b1;
        end
        e.pend = m_pend;
        exp_q.push_back(e);
        m_cyc++;
      end
    end
  end

  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          a = '{seg: seg, an: an, ft: frame_tick, pend: pending};
          chk("scan_out{seg,an,ft,pend}", 32'(a), 32'(e));
        end
      end
    end
  end

  task automatic do_load(input logic [4*ND-1:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int d, input int p);
    int guard = 0;
    while (!(((m_cyc / RD) % ND) == d && (m_cyc % RD) == p) && guard < 4 * FR) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 4 * FR) chk("wait_pos_timeout", 32'(guard), 32'd0);
  endtask

  function automatic logic [4*ND-1:0] rand_val();
    logic [4*ND-1:0] v;
    for (int i = 0; i < ND; i++) begin
      if ($urandom_range(0, 9) < 8) v[4*i +: 4] = 4'($urandom_range(0, 9));
      else v[4*i +: 4] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) v[4*i +: 4] = 4'd0;
    end
    return v;
  endfunction

  task automatic mid_reset(input int d);
    wait_pos(d, 2);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_seg", 32'(seg), 32'h7F);
    chk("rst_mid_an", 32'(an), 32'hF);
    chk("rst_mid_pending", 32'(pending), 32'd0);
    chk("rst_mid_ft", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    lz_blank = 1'b0;
    blank    = 1'b0;
    #3;
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    clk_en = 1'b1;
    run(3);
    rst = 1'b0;

    do_load(16'h1234);
    run(3 * FR);

    wait_pos(1, 1);
    do_load(16'h5678);
    run(2 * FR);

    wait_pos(3, 3);
    do_load(16'h9999);
    run(2 * FR);

    lz_blank = 1'b1;
    do_load(16'h0040);
    run(2 * FR + 2);
    do_load(16'h0000);
    run(2 * FR + 2);
    lz_blank = 1'b0;

    do_load(16'h00A0);
    run(2 * FR);
    blank = 1'b1;
    run(RD + 3);
    blank = 1'b0;

    do_load(16'h4321);
    mid_reset(2);
    run(2 * FR);

    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(0, 7) == 0);
      if (load) value = rand_val();
      if ($urandom_range(0, 40) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 60) == 0) blank = ~blank;
      if (c == 1500) begin
        load = 1'b0;
        mid_reset($urandom_range(0, ND - 1));
      end
      @(negedge clk);
    end
    load  = 1'b0;
    blank = 1'b0;
    run(FR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
